// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - two-port instruction ROM read arbiter with bounded port 1 wait
module inst_rom_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        flush0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       p1_turn;

  // Port 1 wins when alone, or when it has waited out its contention budget.
  always_comb begin
    p1_turn  = req1 && (!req0 || (wait_cnt == WAIT_LIMIT));
    gnt1     = !rst && p1_turn;
    gnt0     = !rst && req0 && !p1_turn;
    rom_ce   = gnt0 || gnt1;
    rom_addr = '0;
    if (gnt1) begin
      rom_addr = addr1;
    end else if (gnt0) begin
      rom_addr = addr0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      wait_cnt <= '0;
    end else begin
      // A flushed port 0 grant still occupies the ROM but its word is dropped.
      rvalid0 <= gnt0 && !flush0;
      rvalid1 <= gnt1;
      if (gnt0 && !flush0) begin
        rdata0 <= rom_inst;
      end
      if (gnt1) begin
        rdata1 <= rom_inst;
      end
      if (req1 && !gnt1) begin
        wait_cnt <= (wait_cnt == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb/tb_inst_rom_arbiter.sv - scoreboard bench for inst_rom_arbiter
module tb_inst_rom_arbiter;
  localparam int MAX_WAIT = 3;

  logic        clk;
  logic        rst;
  logic        req0, flush0, req1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rom_ce;
  logic [31:0] rdata0, rdata1, rom_addr, rom_inst;

  logic [31:0] rom [64];

  inst_rom_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .flush0(flush0), .gnt0(gnt0),
    .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  assign rom_inst = rom_ce ? rom[rom_addr[7:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          starved = 0;
  logic [31:0] hold0 = 32'h0;
  logic [31:0] hold1 = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: port 0 has priority unless port 1 has already been passed over MAX_WAIT times in a row.
  task automatic step(input logic r, input logic q0, input logic [31:0] a0, input logic f0,
                      input logic q1, input logic [31:0] a1);
    logic w0, w1;
    exp_t e;
    @(negedge clk);
    rst = r; req0 = q0; addr0 = a0; flush0 = f0; req1 = q1; addr1 = a1;
    #1;
    w0 = 1'b0;
    w1 = 1'b0;
    if (!r) begin
      if (q0 && q1) begin
        if (starved >= MAX_WAIT) w1 = 1'b1;
        else w0 = 1'b1;
      end else begin
        w0 = q0;
        w1 = q1;
      end
    end
    chk("gnt0", 32'(gnt0), 32'(w0));
    chk("gnt1", 32'(gnt1), 32'(w1));
    chk("rom_ce", 32'(rom_ce), 32'(w0 | w1));
    chk("rom_addr", rom_addr, w1 ? a1 : (w0 ? a0 : 32'h0));
    if (r) begin
      hold0 = 32'h0;
      hold1 = 32'h0;
    end
    e.due = cyc + 1;
    e.v0  = w0 && !f0;
    e.v1  = w1;
    if (e.v0) hold0 = rom[a0[7:2]];
    if (w1) hold1 = rom[a1[7:2]];
    e.d0 = hold0;
    e.d1 = hold1;
    sb.push_back(e);
    if (r || !q1 || w1) starved = 0;
    else starved = starved + 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("rvalid_exclusive", 32'(rvalid0 && rvalid1), 32'h0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("resp_cycle", 32'(e.due), 32'(cyc));
        chk("rvalid0", 32'(rvalid0), 32'(e.v0));
        chk("rdata0", rdata0, e.d0);
        chk("rvalid1", 32'(rvalid1), 32'(e.v1));
        chk("rdata1", rdata1, e.d1);
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; req0 = 1'b0; addr0 = '0; flush0 = 1'b0; req1 = 1'b0; addr1 = '0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[2] = 32'h3401_1100;

    step(1, 1, 32'h0, 0, 1, 32'h0);
    step(1, 1, 32'h0, 0, 1, 32'h0);

    step(0, 1, 32'h8, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < 8; i++) step(0, 1, 32'h20, 0, 1, 32'h40);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    step(0, 1, 32'h0, 0, 0, 32'h0);
    step(0, 1, 32'h4, 1, 0, 32'h0);
    step(0, 1, 32'h8, 0, 0, 32'h0);
    step(0, 0, 32'h0, 1, 0, 32'h0);

    step(0, 0, 32'h0, 0, 1, 32'h10);
    step(0, 0, 32'h0, 0, 1, 32'h14);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    step(0, 1, 32'h30, 0, 1, 32'h50);
    step(0, 1, 32'h34, 0, 1, 32'h50);
    step(1, 1, 32'h38, 0, 1, 32'h50);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h3c, 0, 1, 32'h54);
    step(0, 0, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, $urandom);
    end
    step(0, 0, 32'h0, 0, 0, 32'h0);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
